// File: rtl/dma_block_xfer.sv
// Single-channel block-copy DMA over one shared single-port SRAM: read a word, then write it.
// Latency: RD_LAT+2 cycles per word; done pulses N*(RD_LAT+2)+1 cycles after start (1 for len 0).
// Backpressure: none; memory is always ready, start is ignored while busy, abort ends the block early.
module dma_block_xfer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we_n,
    output logic              mem_ce_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  xfer_cnt
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx;
    logic [1:0]        wait_cnt;
    logic [LEN_W-1:0]  idx_nxt;

    assign idx_nxt = idx + LEN_W'(1);

    // Outputs are registered for the state being entered, so the bus is
    // glitch-free and strobes drop to idle by default on every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            xfer_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ce_n  <= 1'b1;
            mem_we_n  <= 1'b1;
        end else begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ce_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r    <= src_addr;
                        dst_r    <= dst_addr;
                        len_r    <= len;
                        idx      <= '0;
                        xfer_cnt <= '0;
                        busy     <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_addr <= src_addr;
                            mem_ce_n <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (RD_LAT == 0) begin
                        // The write-data register doubles as the word buffer.
                        state     <= WR;
                        mem_addr  <= dst_r + ADDR_W'(idx);
                        mem_wdata <= mem_rdata;
                        mem_ce_n  <= 1'b0;
                        mem_we_n  <= 1'b0;
                    end else begin
                        state    <= RD_WAIT;
                        wait_cnt <= '0;
                    end
                end
                RD_WAIT: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wait_cnt == 2'(RD_LAT - 1)) begin
                        state     <= WR;
                        mem_addr  <= dst_r + ADDR_W'(idx);
                        mem_wdata <= mem_rdata;
                        mem_ce_n  <= 1'b0;
                        mem_we_n  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WR: begin
                    // The write on the bus this cycle always counts, even if aborted.
                    xfer_cnt <= xfer_cnt + LEN_W'(1);
                    idx      <= idx_nxt;
                    if (abort || idx_nxt == len_r) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RD;
                        mem_addr <= src_r + ADDR_W'(idx_nxt);
                        mem_ce_n <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_block_xfer.sv
// Bench for dma_block_xfer: four instances (RD_LAT 0..3) share stimulus, each with its own SRAM model.
// Expected writes come from a plain sequential memory-copy model; timing from per-word cycle arithmetic.
// Memory never stalls; abort and a second start are injected at chosen cycles after the accepted start.
module tb_dma_block_xfer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, init_req;
    logic [7:0] src, dst, len;
    logic [7:0] m_addr [4];
    logic [7:0] m_wdata [4];
    logic [7:0] m_rdata [4];
    logic [7:0] cnt [4];
    logic       we_n [4];
    logic       ce_n [4];
    logic       busy [4];
    logic       done [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dma_block_xfer #(.ADDR_W(8), .DATA_W(8), .LEN_W(8), .RD_LAT(g)) u_dut (
            .clk(clk), .rst(rst), .start(start), .abort(abort),
            .src_addr(src), .dst_addr(dst), .len(len),
            .mem_addr(m_addr[g]), .mem_wdata(m_wdata[g]), .mem_we_n(we_n[g]), .mem_ce_n(ce_n[g]),
            .mem_rdata(m_rdata[g]), .busy(busy[g]), .done(done[g]), .xfer_cnt(cnt[g])
        );
    end

    logic [7:0] mem [4][256];
    logic [7:0] rd_pipe [4][1:3];
    logic [7:0] img [256];
    logic [7:0] exp_d [256];

    // SRAM model: synchronous read delayed through a pipe; RD_LAT 0 reads combinationally.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (init_req) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= img[a];
            end else if (!ce_n[k] && !we_n[k]) begin
                mem[k][m_addr[k]] <= m_wdata[k];
            end
            rd_pipe[k][1] <= (!ce_n[k] && we_n[k]) ? mem[k][m_addr[k]] : 8'h5A;
            rd_pipe[k][2] <= rd_pipe[k][1];
            rd_pipe[k][3] <= rd_pipe[k][2];
        end
    end

    always_comb begin
        m_rdata[0] = mem[0][m_addr[0]];
        for (int k = 1; k < 4; k++) m_rdata[k] = rd_pipe[k][k];
    end

    int         cyc = 0;
    int         wn [4] = '{default: 0};
    int         rn [4] = '{default: 0};
    int         dn [4] = '{default: 0};
    int         cen [4] = '{default: 0};
    int         dcyc [4] = '{default: 0};
    logic [7:0] wa [4][1024];
    logic [7:0] wd [4][1024];
    logic [7:0] ra [4][1024];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (!ce_n[k]) begin
                cen[k] <= cen[k] + 1;
                if (!we_n[k]) begin
                    wa[k][wn[k] % 1024] <= m_addr[k];
                    wd[k][wn[k] % 1024] <= m_wdata[k];
                    wn[k] <= wn[k] + 1;
                end else begin
                    ra[k][rn[k] % 1024] <= m_addr[k];
                    rn[k] <= rn[k] + 1;
                end
            end
            if (done[k]) begin
                dn[k]   <= dn[k] + 1;
                dcyc[k] <= cyc + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Words written and done cycle (counted from the start edge) for a given latency and abort cycle.
    function automatic void model_cnt(input int n, input int a, input int lat, output int nw, output int dc);
        int p;
        p = lat + 2;
        if (n == 0) begin
            nw = 0; dc = 1;
        end else if (a == 0 || a > n * p) begin
            nw = n; dc = n * p + 1;
        end else begin
            nw = (a - 1) / p + (((a - 1) % p == p - 1) ? 1 : 0);
            dc = a + 1;
        end
    endfunction

    task automatic model_data(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] img_ref [256];
        img_ref = img;
        for (int j = 0; j < n; j++) begin
            img_ref[d + 8'(j)] = img_ref[s + 8'(j)];
            exp_d[j] = img_ref[d + 8'(j)];
        end
    endtask

    task automatic load_img();
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
    endtask

    task automatic drive(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n, input int a,
                         input int st2, input logic ab0, output int c0, output logic tmo);
        @(posedge clk); #1;
        src = s; dst = d; len = n; start = 1'b1; abort = ab0;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        src = s ^ 8'h33; dst = d ^ 8'h5C; len = n ^ 8'h0F;
        tmo = 1'b1;
        for (int c = 1; c < 2000; c++) begin
            abort = (c == a);
            start = (c == st2);
            @(posedge clk); #1;
            if (!busy[0] && !busy[1] && !busy[2] && !busy[3]) begin
                tmo = 1'b0;
                break;
            end
        end
        abort = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({busy[k], done[k], ce_n[k], we_n[k], m_addr[k], m_wdata[k], cnt[k]} !== {4'b0011, 24'h0}) begin
                n_fail++;
                $display("FAIL reset_state lat=%0d: got busy=%0b done=%0b ce_n=%0b we_n=%0b addr=%0h wdata=%0h cnt=%0d want 0,0,1,1,0,0,0",
                         k, busy[k], done[k], ce_n[k], we_n[k], m_addr[k], m_wdata[k], cnt[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int c0, nw, dc;
        logic tmo;
        int wb [4];
        int db [4];
        foreach (img[a]) img[a] = 8'($urandom);
        img[8'h10] = 8'hA0; img[8'h11] = 8'hA1; img[8'h12] = 8'hA2; img[8'h13] = 8'hA3;
        load_img();
        model_data(8'h10, 8'h80, 4);
        for (int k = 0; k < 4; k++) begin wb[k] = wn[k]; db[k] = dn[k]; end
        drive(8'h10, 8'h80, 8'd4, 0, 0, 1'b0, c0, tmo);
        n_cmp++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0b want 0", tmo); end
        for (int k = 0; k < 4; k++) begin
            model_cnt(4, 0, k, nw, dc);
            n_cmp++;
            if (wn[k] - wb[k] !== nw) begin
                n_fail++; $display("FAIL basic_wcount lat=%0d: got %0d want %0d", k, wn[k] - wb[k], nw);
            end
            for (int j = 0; j < nw; j++) begin
                n_cmp++;
                if (wa[k][(wb[k] + j) % 1024] !== 8'h80 + 8'(j) || wd[k][(wb[k] + j) % 1024] !== exp_d[j]) begin
                    n_fail++;
                    $display("FAIL basic_write lat=%0d j=%0d: got [%0h]=%0h want [%0h]=%0h", k, j,
                             wa[k][(wb[k] + j) % 1024], wd[k][(wb[k] + j) % 1024], 8'h80 + 8'(j), exp_d[j]);
                end
            end
            n_cmp++;
            if (dn[k] - db[k] !== 1 || dcyc[k] - c0 !== dc + 1) begin
                n_fail++;
                $display("FAIL basic_done lat=%0d: got %0d pulses at cycle %0d want 1 at %0d", k, dn[k] - db[k], dcyc[k] - c0 - 1, dc);
            end
            n_cmp++;
            if (cnt[k] !== 8'(nw)) begin n_fail++; $display("FAIL basic_cnt lat=%0d: got %0d want %0d", k, cnt[k], nw); end
        end
    endtask

    task automatic test_len_zero();
        int c0;
        logic tmo;
        int wb [4];
        int db [4];
        int cb [4];
        for (int k = 0; k < 4; k++) begin wb[k] = wn[k]; db[k] = dn[k]; cb[k] = cen[k]; end
        drive(8'h40, 8'h50, 8'd0, 0, 0, 1'b0, c0, tmo);
        n_cmp++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL len0_timeout: got %0b want 0", tmo); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dn[k] - db[k] !== 1 || dcyc[k] - c0 !== 2) begin
                n_fail++;
                $display("FAIL len0_done lat=%0d: got %0d pulses at cycle %0d want 1 at 1", k, dn[k] - db[k], dcyc[k] - c0 - 1);
            end
            n_cmp++;
            if (cen[k] - cb[k] !== 0 || wn[k] - wb[k] !== 0) begin
                n_fail++; $display("FAIL len0_strobe lat=%0d: got %0d ce cycles want 0", k, cen[k] - cb[k]);
            end
            n_cmp++;
            if (cnt[k] !== 8'd0) begin n_fail++; $display("FAIL len0_cnt lat=%0d: got %0d want 0", k, cnt[k]); end
        end
    endtask

    task automatic test_wrap();
        int c0, nw, dc;
        logic tmo;
        logic [7:0] exp_ra [3];
        int wb [4];
        int rb [4];
        exp_ra[0] = 8'hFE; exp_ra[1] = 8'hFF; exp_ra[2] = 8'h00;
        foreach (img[a]) img[a] = 8'($urandom);
        load_img();
        model_data(8'hFE, 8'hFF, 3);
        for (int k = 0; k < 4; k++) begin wb[k] = wn[k]; rb[k] = rn[k]; end
        drive(8'hFE, 8'hFF, 8'd3, 0, 0, 1'b0, c0, tmo);
        n_cmp++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got %0b want 0", tmo); end
        for (int k = 0; k < 4; k++) begin
            model_cnt(3, 0, k, nw, dc);
            n_cmp++;
            if (wn[k] - wb[k] !== nw || rn[k] - rb[k] !== 3) begin
                n_fail++; $display("FAIL wrap_count lat=%0d: got %0d wr %0d rd want 3 wr 3 rd", k, wn[k] - wb[k], rn[k] - rb[k]);
            end
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (ra[k][(rb[k] + j) % 1024] !== exp_ra[j] || wa[k][(wb[k] + j) % 1024] !== 8'hFF + 8'(j) ||
                    wd[k][(wb[k] + j) % 1024] !== exp_d[j]) begin
                    n_fail++;
                    $display("FAIL wrap_xfer lat=%0d j=%0d: got rd %0h wr [%0h]=%0h want rd %0h wr [%0h]=%0h", k, j,
                             ra[k][(rb[k] + j) % 1024], wa[k][(wb[k] + j) % 1024], wd[k][(wb[k] + j) % 1024],
                             exp_ra[j], 8'hFF + 8'(j), exp_d[j]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int c0, nw, dc, n, a;
        logic [7:0] s, d;
        logic tmo;
        int wb [4];
        int db [4];
        for (int t = 0; t < 8; t++) begin
            s = 8'($urandom); d = 8'($urandom);
            if (t < 2) begin n = 8; a = 9 + t; end
            else begin n = $urandom_range(1, 12); a = $urandom_range(1, n * 5 + 2); end
            foreach (img[i]) img[i] = 8'($urandom);
            load_img();
            model_data(s, d, n);
            for (int k = 0; k < 4; k++) begin wb[k] = wn[k]; db[k] = dn[k]; end
            drive(s, d, 8'(n), a, 0, 1'b0, c0, tmo);
            n_cmp++;
            if (tmo !== 1'b0) begin n_fail++; $display("FAIL abort_timeout t=%0d: got %0b want 0", t, tmo); end
            for (int k = 0; k < 4; k++) begin
                model_cnt(n, a, k, nw, dc);
                n_cmp++;
                if (wn[k] - wb[k] !== nw) begin
                    n_fail++; $display("FAIL abort_wcount t=%0d lat=%0d: got %0d want %0d", t, k, wn[k] - wb[k], nw);
                end
                for (int j = 0; j < nw; j++) begin
                    n_cmp++;
                    if (wa[k][(wb[k] + j) % 1024] !== d + 8'(j) || wd[k][(wb[k] + j) % 1024] !== exp_d[j]) begin
                        n_fail++;
                        $display("FAIL abort_write t=%0d lat=%0d j=%0d: got [%0h]=%0h want [%0h]=%0h", t, k, j,
                                 wa[k][(wb[k] + j) % 1024], wd[k][(wb[k] + j) % 1024], d + 8'(j), exp_d[j]);
                    end
                end
                n_cmp++;
                if (dn[k] - db[k] !== 1 || dcyc[k] - c0 !== dc + 1) begin
                    n_fail++;
                    $display("FAIL abort_done t=%0d lat=%0d: got %0d pulses at cycle %0d want 1 at %0d", t, k,
                             dn[k] - db[k], dcyc[k] - c0 - 1, dc);
                end
                n_cmp++;
                if (cnt[k] !== 8'(nw)) begin n_fail++; $display("FAIL abort_cnt t=%0d lat=%0d: got %0d want %0d", t, k, cnt[k], nw); end
            end
        end
    endtask

    task automatic test_start_ignored();
        int c0, nw, dc;
        logic tmo;
        int wb [4];
        int db [4];
        foreach (img[a]) img[a] = 8'($urandom);
        load_img();
        model_data(8'h30, 8'hA0, 4);
        for (int k = 0; k < 4; k++) begin wb[k] = wn[k]; db[k] = dn[k]; end
        // abort alongside the accepted start, then a second start mid-transfer with other operands
        drive(8'h30, 8'hA0, 8'd4, 0, 2, 1'b1, c0, tmo);
        n_cmp++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL restart_timeout: got %0b want 0", tmo); end
        for (int k = 0; k < 4; k++) begin
            model_cnt(4, 0, k, nw, dc);
            n_cmp++;
            if (wn[k] - wb[k] !== nw) begin
                n_fail++; $display("FAIL restart_wcount lat=%0d: got %0d want %0d", k, wn[k] - wb[k], nw);
            end
            for (int j = 0; j < nw; j++) begin
                n_cmp++;
                if (wa[k][(wb[k] + j) % 1024] !== 8'hA0 + 8'(j) || wd[k][(wb[k] + j) % 1024] !== exp_d[j]) begin
                    n_fail++;
                    $display("FAIL restart_write lat=%0d j=%0d: got [%0h]=%0h want [%0h]=%0h", k, j,
                             wa[k][(wb[k] + j) % 1024], wd[k][(wb[k] + j) % 1024], 8'hA0 + 8'(j), exp_d[j]);
                end
            end
            n_cmp++;
            if (dn[k] - db[k] !== 1 || dcyc[k] - c0 !== dc + 1 || cnt[k] !== 8'(nw)) begin
                n_fail++;
                $display("FAIL restart_done lat=%0d: got %0d pulses at cycle %0d cnt %0d want 1 at %0d cnt %0d", k,
                         dn[k] - db[k], dcyc[k] - c0 - 1, cnt[k], dc, nw);
            end
        end
    endtask

    task automatic test_reset_mid();
        int db [4];
        foreach (img[a]) img[a] = 8'($urandom);
        load_img();
        for (int k = 0; k < 4; k++) db[k] = dn[k];
        @(posedge clk); #1;
        src = 8'h20; dst = 8'h60; len = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (busy[k] !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before lat=%0d: got %0b want 1", k, busy[k]); end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({busy[k], done[k], ce_n[k], we_n[k], m_addr[k], cnt[k]} !== {4'b0011, 16'h0}) begin
                n_fail++;
                $display("FAIL rstmid_state lat=%0d: got busy=%0b done=%0b ce_n=%0b we_n=%0b addr=%0h cnt=%0d want 0,0,1,1,0,0",
                         k, busy[k], done[k], ce_n[k], we_n[k], m_addr[k], cnt[k]);
            end
        end
        repeat (60) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dn[k] - db[k] !== 0 || busy[k] !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_nodone lat=%0d: got %0d pulses busy=%0b want 0 pulses busy=0", k, dn[k] - db[k], busy[k]);
            end
        end
    endtask

    task automatic test_random();
        int c0, nw, dc, n;
        logic [7:0] s, d;
        logic tmo;
        int wb [4];
        int db [4];
        for (int t = 0; t < 10; t++) begin
            s = 8'($urandom); d = 8'($urandom); n = $urandom_range(1, 16);
            if (t == 9) n = 5;
            foreach (img[i]) img[i] = 8'($urandom);
            load_img();
            model_data(s, d, n);
            for (int k = 0; k < 4; k++) begin wb[k] = wn[k]; db[k] = dn[k]; end
            drive(s, d, 8'(n), 0, 0, 1'b0, c0, tmo);
            n_cmp++;
            if (tmo !== 1'b0) begin n_fail++; $display("FAIL random_timeout t=%0d: got %0b want 0", t, tmo); end
            for (int k = 0; k < 4; k++) begin
                model_cnt(n, 0, k, nw, dc);
                n_cmp++;
                if (wn[k] - wb[k] !== nw) begin
                    n_fail++; $display("FAIL random_wcount t=%0d lat=%0d: got %0d want %0d", t, k, wn[k] - wb[k], nw);
                end
                for (int j = 0; j < nw; j++) begin
                    n_cmp++;
                    if (wa[k][(wb[k] + j) % 1024] !== d + 8'(j) || wd[k][(wb[k] + j) % 1024] !== exp_d[j]) begin
                        n_fail++;
                        $display("FAIL random_write t=%0d lat=%0d j=%0d: got [%0h]=%0h want [%0h]=%0h", t, k, j,
                                 wa[k][(wb[k] + j) % 1024], wd[k][(wb[k] + j) % 1024], d + 8'(j), exp_d[j]);
                    end
                end
                n_cmp++;
                if (dn[k] - db[k] !== 1 || dcyc[k] - c0 !== dc + 1 || cnt[k] !== 8'(nw)) begin
                    n_fail++;
                    $display("FAIL random_done t=%0d lat=%0d: got %0d pulses at cycle %0d cnt %0d want 1 at %0d cnt %0d", t, k,
                             dn[k] - db[k], dcyc[k] - c0 - 1, cnt[k], dc, nw);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; init_req = 1'b0;
        src = 8'h0; dst = 8'h0; len = 8'h0;
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
